// File: rtl/rr_onehot_sel_pkg.sv
// Shared types and constants for the round-robin one-hot select generator.
package rr_onehot_sel_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef logic [IDX_W-1:0] req_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Requester index to one-hot select vector.
    function automatic logic [N_REQ-1:0] idx_to_sel(input req_idx_t idx);
        logic [N_REQ-1:0] s;
        s      = '0;
        s[idx] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/rr_onehot_sel_if.sv
// Request/release and one-hot select bundle between requesters and the select generator.
interface rr_onehot_sel_if;
    import rr_onehot_sel_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic             s0;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             valid;
    logic             onehot_err;

    modport master (
        output req, done,
        input  s0, s1, s2, s3, valid, onehot_err
    );

    modport slave (
        input  req, done,
        output s0, s1, s2, s3, valid, onehot_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request scanning from ptr upward, mod N_REQ.
module rr_pick
    import rr_onehot_sel_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  req_idx_t         ptr_i,
    output req_idx_t         idx_c_o,
    output logic             any_c_o
);

    req_idx_t cand;

    always_comb begin
        idx_c_o = ptr_i;
        any_c_o = 1'b0;
        cand    = ptr_i;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr_i + req_idx_t'(k);
            if (!any_c_o && req_i[cand]) begin
                idx_c_o = cand;
                any_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_onehot_sel.sv
// Round-robin arbiter over 4 requesters driving registered one-hot selects s0..s3.
// Optional sticky one-hot checker enabled by defining RR_ONEHOT_CHECK_EN.
module rr_onehot_sel
    import rr_onehot_sel_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_onehot_sel_if.slave  sel_if
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic             HOLD_EN   = (HOLD_MAX != 0);

    state_e            state_q, state_d;
    req_idx_t          ptr_q, ptr_d;
    req_idx_t          owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  sel_q, sel_d;
    logic              valid_q, valid_d;

    req_idx_t          pick_ptr_c;
    req_idx_t          pick_idx_c;
    logic              pick_any_c;
    logic              release_c;

    // On release the scan starts just past the owner, so the picker sees the updated pointer.
    assign pick_ptr_c = (state_q == GRANT) ? owner_q + req_idx_t'(1) : ptr_q;
    assign release_c  = sel_if.done || !sel_if.req[owner_q] || (HOLD_EN && (cnt_q == HOLD_LAST));

    rr_pick u_pick (
        .req_i   (sel_if.req),
        .ptr_i   (pick_ptr_c),
        .idx_c_o (pick_idx_c),
        .any_c_o (pick_any_c)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                sel_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
                if (pick_any_c) begin
                    state_d = GRANT;
                    owner_d = pick_idx_c;
                    sel_d   = idx_to_sel(pick_idx_c);
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (release_c) begin
                    ptr_d = owner_q + req_idx_t'(1);
                    cnt_d = '0;
                    if (pick_any_c) begin
                        owner_d = pick_idx_c;
                        sel_d   = idx_to_sel(pick_idx_c);
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sel_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign sel_if.s0    = sel_q[0];
    assign sel_if.s1    = sel_q[1];
    assign sel_if.s2    = sel_q[2];
    assign sel_if.s3    = sel_q[3];
    assign sel_if.valid = valid_q;

`ifdef RR_ONEHOT_CHECK_EN
    logic err_q, err_d;
    logic sel_onehot_c;

    // Flags any cycle where the select vector disagrees with valid; sticky until reset.
    assign sel_onehot_c = ($countones(sel_q) == 1);
    assign err_d        = err_q || (valid_q ? !sel_onehot_c : (sel_q != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sel_if.onehot_err = err_q;
`else
    assign sel_if.onehot_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_onehot_sel.sv
// Directed bench for rr_onehot_sel: one unlimited-hold instance and one with HOLD_MAX=3.
module tb_rr_onehot_sel;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    rr_onehot_sel_if bus0 ();
    rr_onehot_sel_if bus3 ();

    rr_onehot_sel #(.HOLD_MAX(0), .CNT_W(8)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel_if (bus0)
    );

    rr_onehot_sel #(.HOLD_MAX(3), .CNT_W(8)) u_dut_h (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel_if (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sel0();
        return {4'b0, bus0.s3, bus0.s2, bus0.s1, bus0.s0};
    endfunction

    function automatic logic [7:0] sel3();
        return {4'b0, bus3.s3, bus3.s2, bus3.s1, bus3.s0};
    endfunction

    logic [7:0] exp_t3 [5];
    logic [7:0] exp_cnt [6];
    logic [7:0] exp_alt [9];

    initial begin
        n_vec = 0;
        n_bad = 0;
        exp_t3  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
        exp_cnt = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        exp_alt = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02};

        rst_n     = 1'b0;
        bus0.req  = 4'b0000;
        bus0.done = 1'b0;
        bus3.req  = 4'b0000;
        bus3.done = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_sel",   sel0(), 8'h00);
        check_eq("rst_valid", 8'(bus0.valid), 8'h00);
        check_eq("rst_err",   8'(bus0.onehot_err), 8'h00);
        check_eq("rst_ptr",   8'(u_dut.ptr_q), 8'h00);
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("idle_sel",   sel0(), 8'h00);
            check_eq("idle_valid", 8'(bus0.valid), 8'h00);
        end

        // 1010 from ptr=0: s1, then done hands over to s3 without a bubble
        bus0.req = 4'b1010;
        @(negedge clk);
        check_eq("t2_s1",    sel0(), 8'h02);
        check_eq("t2_valid", 8'(bus0.valid), 8'h01);
        bus0.done = 1'b1;
        @(negedge clk);
        check_eq("t2_s3",    sel0(), 8'h08);
        check_eq("t2_valid2", 8'(bus0.valid), 8'h01);
        bus0.req = 4'b0000;
        @(negedge clk);
        check_eq("t2_idle",  sel0(), 8'h00);
        check_eq("t2_valid3", 8'(bus0.valid), 8'h00);
        check_eq("t2_ptr",   8'(u_dut.ptr_q), 8'h00);

        // done while idle is ignored
        @(negedge clk);
        bus0.done = 1'b0;
        check_eq("idle_done", sel0(), 8'h00);

        // All requesting, done every 2nd cycle: s0,s1,s2,s3,s0
        bus0.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t3_first", sel0(), exp_t3[i]);
            bus0.done = 1'b0;
            @(negedge clk);
            check_eq("t3_hold", sel0(), exp_t3[i]);
            bus0.done = 1'b1;
        end
        @(negedge clk);
        check_eq("t3_next", sel0(), 8'h02);
        bus0.req  = 4'b0000;
        bus0.done = 1'b0;
        @(negedge clk);
        check_eq("t3_idle", sel0(), 8'h00);
        check_eq("t3_ptr",  8'(u_dut.ptr_q), 8'h02);

        // Owner s2 drops its request while s0 waits
        bus0.req = 4'b0101;
        @(negedge clk);
        check_eq("t5_s2", sel0(), 8'h04);
        bus0.req = 4'b0111;
        @(negedge clk);
        check_eq("t5_hold", sel0(), 8'h04);
        bus0.req = 4'b0011;
        @(negedge clk);
        check_eq("t5_s0",  sel0(), 8'h01);
        check_eq("t5_ptr", 8'(u_dut.ptr_q), 8'h03);
        bus0.req = 4'b0000;
        @(negedge clk);
        check_eq("t5_idle", sel0(), 8'h00);

        // Reset asserted mid-grant clears selects immediately
        bus0.req = 4'b0010;
        @(negedge clk);
        check_eq("t6_s1", sel0(), 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_sel",   sel0(), 8'h00);
        check_eq("t6_rst_valid", 8'(bus0.valid), 8'h00);
        check_eq("t6_rst_ptr",   8'(u_dut.ptr_q), 8'h00);
        bus0.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // HOLD_MAX=3, sole requester: continuous s0, hold counter restarts every 3 cycles
        bus3.req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("t4_sel", sel3(), 8'h01);
            check_eq("t4_cnt", 8'(u_dut_h.cnt_q), exp_cnt[i]);
        end
        check_eq("t4_valid", 8'(bus3.valid), 8'h01);
        bus3.req = 4'b0000;
        @(negedge clk);
        check_eq("t4_idle", sel3(), 8'h00);

        // HOLD_MAX=3 with two requesters alternates every 3 cycles
        bus3.req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_eq("t4_alt", sel3(), exp_alt[i]);
        end
        bus3.req = 4'b0000;
        @(negedge clk);
        check_eq("t4_alt_idle", sel3(), 8'h00);

`ifdef RR_ONEHOT_CHECK_EN
        check_eq("err_clean", 8'(bus0.onehot_err), 8'h00);
        force u_dut.sel_q = 4'b0011;
        @(negedge clk);
        release u_dut.sel_q;
        check_eq("err_set", 8'(bus0.onehot_err), 8'h01);
        @(negedge clk);
        check_eq("err_sticky", 8'(bus0.onehot_err), 8'h01);
        check_eq("err_sel_back", sel0(), 8'h00);
        rst_n = 1'b0;
        #1;
        check_eq("err_rst", 8'(bus0.onehot_err), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
`else
        check_eq("err_tied0", 8'(bus0.onehot_err), 8'h00);
        check_eq("err_tied3", 8'(bus3.onehot_err), 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
